// File: rtl/rtype_seq_ctrl.sv
// Multi-cycle sequencer for the R-type datapath: accepts one instruction per
// handshake and steps it through DECODE, EXECUTE and WRITEBACK with registered controls.
module rtype_seq_ctrl #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [31:0]        instr,
    output logic [4:0]         rf_ra,
    output logic [4:0]         rf_rb,
    output logic [4:0]         rf_rw,
    output logic               rf_we,
    output logic [2:0]         alu_ctl,
    input  logic [31:0]        alu_result,
    output logic [31:0]        wb_data,
    output logic               busy,
    output logic               done,
    output logic               illegal,
    output logic [COUNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DEC  = 2'd1,
        EXE  = 2'd2,
        WB   = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] ir;
    logic        dec_legal;
    logic [2:0]  dec_ctl;

    // Returns {legal, alu_ctl}; shamt plays no part in legality.
    function automatic logic [3:0] decode_funct(input logic [5:0] opcode, input logic [5:0] funct);
        logic [3:0] r;
        r = 4'b0000;
        if (opcode == 6'd0) begin
            case (funct)
                6'b100000, 6'b100001: r = 4'b1010;
                6'b100010, 6'b100011: r = 4'b1110;
                6'b100100:            r = 4'b1000;
                6'b100101:            r = 4'b1001;
                6'b100110:            r = 4'b1011;
                6'b100111:            r = 4'b1100;
                6'b101010:            r = 4'b1111;
                default:              r = 4'b0000;
            endcase
        end
        return r;
    endfunction

    assign {dec_legal, dec_ctl} = decode_funct(ir[31:26], ir[5:0]);

    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ir          <= '0;
            wb_data     <= '0;
            alu_ctl     <= '0;
            rf_ra       <= '0;
            rf_rb       <= '0;
            rf_rw       <= '0;
            rf_we       <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            instr_count <= '0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            rf_we   <= 1'b0;
            case (state)
                IDLE: begin
                    // Read addresses come straight from the accepted word so they are valid in DEC.
                    if (instr_valid) begin
                        ir    <= instr;
                        rf_ra <= instr[25:21];
                        rf_rb <= instr[20:16];
                        state <= DEC;
                    end
                end
                DEC: begin
                    if (dec_legal) begin
                        alu_ctl <= dec_ctl;
                        state   <= EXE;
                    end else begin
                        illegal <= 1'b1;
                        state   <= IDLE;
                    end
                end
                EXE: begin
                    alu_ctl <= '0;
                    wb_data <= alu_result;
                    rf_rw   <= ir[15:11];
                    rf_we   <= (ir[15:11] != 5'd0);
                    done    <= 1'b1;
                    state   <= WB;
                end
                WB: begin
                    instr_count <= instr_count + 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
